csa_accumulator: RTL

Sequential multi-operand accumulator built on carry-save arithmetic. Accepts a packet of unsigned operands over a valid/ready stream, compresses each beat into redundant sum/carry registers with a 3:2 carry-save step (no carry propagation per beat), then resolves the redundant pair with a chunked carry-propagate adder and presents the total on a valid/ready output. It is the stage that feeds a block's result consumer from an operand source wherever more than three operands must be summed.

---
 rtl/csa_accumulator.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/csa_accumulator.sv
// csa_accumulator
//   Multi-operand unsigned accumulator. Each accepted beat is folded into a
//   redundant sum/carry pair with a 3:2 carry-save step, so no carry has to
//   ripple while beats arrive. After the in_last beat, the redundant pair is
//   resolved CHUNK bits per cycle by a small carry-propagate adder. The total
//   is then held on a valid/ready output.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand stream handshake (ready only while accumulating)
//   in_data             unsigned operand, zero-extended to ACC_W
//   in_last             final operand of the packet, sampled with the beat
//   out_valid/out_ready result handshake
//   out_sum             packet total modulo 2^ACC_W
//   out_count           operand count, saturating at 2^COUNT_W
//   out_ovf             packet held more than 2^COUNT_W operands
module csa_accumulator #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 4,
   parameter int CHUNK   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH+COUNT_W-1:0]   out_sum,
   output logic [COUNT_W:0]           out_count,
   output logic                       out_ovf
);

   localparam int ACC_W  = WIDTH + COUNT_W;
   localparam int NCHUNK = (ACC_W + CHUNK - 1) / CHUNK;
   localparam int PAD_W  = NCHUNK * CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int BW     = (PAD_W > 1) ? $clog2(PAD_W) : 1;

   localparam logic [KW-1:0]    LAST_K  = KW'(NCHUNK - 1);
   localparam logic [COUNT_W:0] CNT_MAX = {1'b1, {COUNT_W{1'b0}}};

   typedef enum logic [1:0] {
      ACCUM,
      RESOLVE,
      OUTPUT
   } state_t;

   state_t              state;
   logic [ACC_W-1:0]    s_q, c_q, r_q;
   logic                cy_q;
   logic [COUNT_W:0]    cnt_q;
   logic                ovf_q;
   logic [KW-1:0]       k_q;

   logic                beat;
   logic [ACC_W-1:0]    d_ext;
   logic [ACC_W-1:0]    maj;

   // Chunked resolve datapath: S/C/R are widened to a whole number of
   // chunks so the final (possibly short) chunk needs no special case.
   // The zero padding only feeds the discarded carry-out.
   logic [BW-1:0]       base;
   logic [PAD_W-1:0]    s_pad, c_pad, r_pad;
   logic [CHUNK-1:0]    s_chunk, c_chunk;
   logic [CHUNK:0]      chunk_sum;
   logic [ACC_W-1:0]    r_next;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == OUTPUT);
   assign out_sum   = r_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

   assign beat  = in_valid && (state == ACCUM);
   assign d_ext = {{COUNT_W{1'b0}}, in_data};
   assign maj   = (s_q & c_q) | (s_q & d_ext) | (c_q & d_ext);

   always_comb begin
      base      = BW'(k_q) * BW'(CHUNK);
      s_pad     = '0;
      c_pad     = '0;
      r_pad     = '0;
      s_pad[ACC_W-1:0] = s_q;
      c_pad[ACC_W-1:0] = c_q;
      r_pad[ACC_W-1:0] = r_q;
      s_chunk   = CHUNK'(s_pad >> base);
      c_chunk   = CHUNK'(c_pad >> base);
      chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};
      r_pad     = (r_pad & ~(PAD_W'({CHUNK{1'b1}}) << base))
                | (PAD_W'(chunk_sum[CHUNK-1:0]) << base);
      r_next    = r_pad[ACC_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
         s_q   <= '0;
         c_q   <= '0;
         r_q   <= '0;
         cy_q  <= 1'b0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         k_q   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (beat) begin
                  s_q <= s_q ^ c_q ^ d_ext;
                  c_q <= {maj[ACC_W-2:0], 1'b0};
                  if (cnt_q == CNT_MAX) begin
                     ovf_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
                  if (in_last) begin
                     state <= RESOLVE;
                     k_q   <= '0;
                     cy_q  <= 1'b0;
                  end
               end
            end
            RESOLVE: begin
               r_q  <= r_next;
               cy_q <= chunk_sum[CHUNK];
               if (k_q == LAST_K) begin
                  k_q   <= '0;
                  state <= OUTPUT;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  s_q   <= '0;
                  c_q   <= '0;
                  cnt_q <= '0;
                  ovf_q <= 1'b0;
                  state <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule
